// File: rtl/capi_mmio_req_stage.sv
// capi_mmio_req_stage
// Front end for PSL MMIO requests. It registers one request at a time and drives
// the qualified write/read strobes into the AFU decoders. It also returns the
// mandatory MMIO ack, with read data where the request was a read.
//
// Optional build macro: CAPI_MMIO_PARITY_EN
//   When defined, the block checks the address and write-data parity in CAPT.
//   A bad request gets no strobe, is acked quickly with all-ones data, and
//   raises a one-cycle perr pulse.
//   When undefined, the parity inputs are ignored and there is no perr port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for ha_mmval; a valid request is latched here
// CAPT  | latched request moved onto wa/wd; read/write (and parity) decided
// WR    | we asserted for this single cycle; ack delay loaded into counter
// RD    | re asserted for this single cycle; read latency loaded into counter
// WAIT  | counter runs down; read data captured on the cycle it reads 1
// ACK   | ah_mmack pulse with return data; back to IDLE next cycle
//
// Bit order follows the PSL big-endian convention, with bit 0 as the MSB.
// wa = {ha_mmad, ha_mmdw}, so the LSB of wa marks a 64-bit access.
module capi_mmio_req_stage #(
   parameter int addr_width = 25,
   parameter int ack_dly    = 2,
   parameter int rd_lat     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ha_mmval,
   input  logic                  ha_mmrnw,
   input  logic                  ha_mmdw,
   input  logic [0:23]           ha_mmad,
   input  logic                  ha_mmadpar,
   input  logic [0:63]           ha_mmdata,
   input  logic                  ha_mmdatapar,
   output logic [0:addr_width-1] wa,
   output logic                  we,
   output logic [0:63]           wd,
   output logic                  re,
   input  logic [0:63]           rd_data,
   output logic                  ah_mmack,
   output logic [0:63]           ah_mmdata,
   output logic                  ah_mmdatapar,
   output logic                  mmio_err
`ifdef CAPI_MMIO_PARITY_EN
   ,
   output logic                  perr
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CAPT = 3'd1,
      S_WR   = 3'd2,
      S_RD   = 3'd3,
      S_WAIT = 3'd4,
      S_ACK  = 3'd5
   } state_t;

   // Counter loads are 4 bits wide, which limits both delays to 1..15.
   localparam logic [3:0] c_ack_dly = 4'(ack_dly);
   localparam logic [3:0] c_rd_lat  = 4'(rd_lat);

   state_t        r_state;
   state_t        w_next;

   logic          r_rnw;
   logic          r_dw;
   logic [0:23]   r_ad;
   logic [0:63]   r_data;
   logic [3:0]    r_cnt;

   logic          w_accept;
   logic          w_bad;
   logic [0:63]   w_ack_data;

   assign w_accept = (r_state == S_IDLE) && ha_mmval;

`ifdef CAPI_MMIO_PARITY_EN
   logic          r_bad;
   logic          r_perr;
   logic          w_bad_in;

   // Odd parity: XOR over the field plus its parity bit must be 1.
   // Write data parity is only meaningful on writes.
   assign w_bad_in = ~(^{ha_mmad, ha_mmadpar}) |
                     (~ha_mmrnw & ~(^{ha_mmdata, ha_mmdatapar}));
   assign w_bad    = r_bad;
   assign perr     = r_perr;

   // Parity verdict latched with the request; perr is high for the CAPT cycle only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bad  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         r_perr <= w_accept & w_bad_in;
         if (w_accept) begin
            r_bad <= w_bad_in;
         end
      end
   end
`else
   logic          w_unused_par;

   assign w_unused_par = ha_mmadpar ^ ha_mmdatapar;
   assign w_bad        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode. A bad-parity request skips the strobe state and is acked after one WAIT cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ha_mmval) begin
               w_next = S_CAPT;
            end
         end
         S_CAPT: begin
            if (w_bad) begin
               w_next = S_WAIT;
            end else if (r_rnw) begin
               w_next = S_RD;
            end else begin
               w_next = S_WR;
            end
         end
         S_WR:    w_next = S_WAIT;
         S_RD:    w_next = S_WAIT;
         S_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_next = S_ACK;
            end
         end
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request latch; it only loads in IDLE, so a request that arrives while busy cannot disturb it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rnw  <= 1'b0;
         r_dw   <= 1'b0;
         r_ad   <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_rnw  <= ha_mmrnw;
         r_dw   <= ha_mmdw;
         r_ad   <= ha_mmad;
         r_data <= ha_mmdata;
      end
   end

   // Down-counter: loaded by WR/RD (or to 1 on a parity reject), runs down in WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= 4'd0;
      end else begin
         case (r_state)
            S_CAPT: begin
               if (w_bad) begin
                  r_cnt <= 4'd1;
               end
            end
            S_WR:   r_cnt <= c_ack_dly;
            S_RD:   r_cnt <= c_rd_lat;
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Decoder bus: wa/wd move in CAPT and hold until the next capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wa <= '0;
         wd <= '0;
      end else if (r_state == S_CAPT) begin
         wa <= addr_width'({r_ad, r_dw});
         wd <= r_data;
      end
   end

   // Strobes are registered from the next state, so each is high only in its own WR/RD cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we <= 1'b0;
         re <= 1'b0;
      end else begin
         we <= (w_next == S_WR);
         re <= (w_next == S_RD);
      end
   end

   // On a read, rd_data is sampled on the same edge that enters ACK, which is when the counter reads 1.
   assign w_ack_data = w_bad ? {64{1'b1}} : (r_rnw ? rd_data : 64'd0);

   // Ack pulse and return data. Outside ACK the data is 0, so its odd parity bit is 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ah_mmack     <= 1'b0;
         ah_mmdata    <= '0;
         ah_mmdatapar <= 1'b1;
      end else if (w_next == S_ACK) begin
         ah_mmack     <= 1'b1;
         ah_mmdata    <= w_ack_data;
         ah_mmdatapar <= ~(^w_ack_data);
      end else begin
         ah_mmack     <= 1'b0;
         ah_mmdata    <= '0;
         ah_mmdatapar <= 1'b1;
      end
   end

   // Sticky overlap flag: any ha_mmval outside IDLE (ACK included) is dropped and recorded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mmio_err <= 1'b0;
      end else if (ha_mmval && (r_state != S_IDLE)) begin
         mmio_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_capi_mmio_req_stage.sv
// Directed bench for capi_mmio_req_stage (ack_dly=2, rd_lat=2).
// Cycle numbering: cycle 0 is the cycle in which ha_mmval is driven high.
// Outputs are sampled at the negedge of each later cycle.
module tb_capi_mmio_req_stage;

   logic          clk = 1'b0;
   logic          reset;
   logic          ha_mmval;
   logic          ha_mmrnw;
   logic          ha_mmdw;
   logic [0:23]   ha_mmad;
   logic          ha_mmadpar;
   logic [0:63]   ha_mmdata;
   logic          ha_mmdatapar;
   logic [0:24]   wa;
   logic          we;
   logic [0:63]   wd;
   logic          re;
   logic [0:63]   rd_data;
   logic          ah_mmack;
   logic [0:63]   ah_mmdata;
   logic          ah_mmdatapar;
   logic          mmio_err;
`ifdef CAPI_MMIO_PARITY_EN
   logic          perr;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // per-request observations
   int            n_we, c_we, n_re, c_re, n_ack, c_ack, c_ack_last, n_both, n_perr, c_perr;
   logic [0:63]   ack_data;
   logic          ack_par;
   logic [0:24]   wa2;
   logic [0:63]   wd2;

   localparam logic [0:63] junk = 64'hDEAD_BEEF_0BAD_F00D;

   capi_mmio_req_stage #(.addr_width(25), .ack_dly(2), .rd_lat(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .ha_mmval     (ha_mmval),
      .ha_mmrnw     (ha_mmrnw),
      .ha_mmdw      (ha_mmdw),
      .ha_mmad      (ha_mmad),
      .ha_mmadpar   (ha_mmadpar),
      .ha_mmdata    (ha_mmdata),
      .ha_mmdatapar (ha_mmdatapar),
      .wa           (wa),
      .we           (we),
      .wd           (wd),
      .re           (re),
      .rd_data      (rd_data),
      .ah_mmack     (ah_mmack),
      .ah_mmdata    (ah_mmdata),
      .ah_mmdatapar (ah_mmdatapar),
      .mmio_err     (mmio_err)
`ifdef CAPI_MMIO_PARITY_EN
      ,
      .perr         (perr)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rnw, input logic dw, input logic [0:23] ad,
                        input logic [0:63] data, input logic flip);
      ha_mmval     = 1'b1;
      ha_mmrnw     = rnw;
      ha_mmdw      = dw;
      ha_mmad      = ad;
      ha_mmadpar   = ~(^ad) ^ flip;
      ha_mmdata    = data;
      ha_mmdatapar = ~(^data);
   endtask

   // Issues a request at the current negedge, then observes ncyc cycles.
   task automatic run_req(input logic rnw, input logic dw, input logic [0:23] ad,
                          input logic [0:63] data, input logic flip,
                          input int extra_cyc, input int rd_cyc,
                          input logic [0:63] rd_val, input int ncyc);
      n_we = 0; c_we = -1; n_re = 0; c_re = -1; n_ack = 0; c_ack = -1; c_ack_last = -1;
      n_both = 0; n_perr = 0; c_perr = -1;
      ack_data = '0; ack_par = 1'b0; wa2 = '0; wd2 = '0;
      drive(rnw, dw, ad, data, flip);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         ha_mmval = 1'b0;
         if (we) begin n_we++; c_we = c; end
         if (re) begin n_re++; c_re = c; end
         if (we && re) n_both++;
         if (ah_mmack) begin
            n_ack++;
            if (n_ack == 1) c_ack = c;
            c_ack_last = c;
            ack_data = ah_mmdata;
            ack_par  = ah_mmdatapar;
         end
`ifdef CAPI_MMIO_PARITY_EN
         if (perr) begin n_perr++; c_perr = c; end
`endif
         if (c == 2) begin wa2 = wa; wd2 = wd; end
         rd_data = (c == rd_cyc) ? rd_val : junk;
         if (c == extra_cyc) drive(1'b0, 1'b1, 24'h000020, 64'h77, 1'b0);
      end
   endtask

   initial begin
      int n_rst_ack;
      reset = 1'b0; ha_mmval = 1'b0; ha_mmrnw = 1'b0; ha_mmdw = 1'b0; ha_mmad = '0;
      ha_mmadpar = 1'b1; ha_mmdata = '0; ha_mmdatapar = 1'b1; rd_data = junk;
      repeat (2) @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_re", re, 0);
      chk("rst_ack", ah_mmack, 0);
      chk("rst_err", mmio_err, 0);
      chk("rst_wa", wa, 0);
      chk("rst_wd", wd, 0);
      chk("rst_ahdata", ah_mmdata, 0);
      chk("rst_ahpar", ah_mmdatapar, 1);
`ifdef CAPI_MMIO_PARITY_EN
      chk("rst_perr", perr, 0);
`endif
      reset = 1'b1;
      @(negedge clk);

      // 1: 64-bit write
      run_req(1'b0, 1'b1, 24'h000010, 64'hA5, 1'b0, 0, 0, junk, 8);
      chk("t1_we_count", n_we, 1);
      chk("t1_we_cycle", c_we, 2);
      chk("t1_re_count", n_re, 0);
      chk("t1_wa", wa2, 25'h000021);
      chk("t1_wd", wd2, 64'hA5);
      chk("t1_ack_count", n_ack, 1);
      chk("t1_ack_cycle", c_ack, 5);
      chk("t1_ack_data", ack_data, 0);
      chk("t1_ack_par", ack_par, 1);
      chk("t1_err", mmio_err, 0);
      chk("t1_wa_hold", wa, 25'h000021);

      // 2: 32-bit read, data valid only in cycle 4
      run_req(1'b1, 1'b0, 24'h000004, 64'hA5, 1'b0, 0, 4, 64'h1234, 8);
      chk("t2_re_count", n_re, 1);
      chk("t2_re_cycle", c_re, 2);
      chk("t2_we_count", n_we, 0);
      chk("t2_wa", wa2, 25'h000008);
      chk("t2_ack_cycle", c_ack, 5);
      chk("t2_ack_count", n_ack, 1);
      chk("t2_ack_data", ack_data, 64'h1234);
      chk("t2_ack_par", ack_par, 0);
      chk("t2_ahdata_after", ah_mmdata, 0);

      // 3: overlapping request one cycle after the first
      run_req(1'b0, 1'b1, 24'h000030, 64'h5A, 1'b0, 1, 0, junk, 10);
      chk("t3_we_count", n_we, 1);
      chk("t3_ack_count", n_ack, 1);
      chk("t3_ack_cycle", c_ack, 5);
      chk("t3_wa", wa2, 25'h000061);
      chk("t3_wd", wd2, 64'h5A);
      chk("t3_wd_hold", wd, 64'h5A);
      chk("t3_err", mmio_err, 1);
      run_req(1'b0, 1'b0, 24'h000001, 64'h3, 1'b0, 0, 0, junk, 8);
      chk("t3_next_ack", c_ack, 5);
      chk("t3_err_sticky", mmio_err, 1);

      // 4: reset during WAIT of a write
      drive(1'b0, 1'b1, 24'h000040, 64'h11, 1'b0);
      n_rst_ack = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         ha_mmval = 1'b0;
         if (ah_mmack) n_rst_ack++;
      end
      chk("t4_wa_before", wa, 25'h000081);
      reset = 1'b0;
      #1;
      chk("t4_wa_rst", wa, 0);
      chk("t4_wd_rst", wd, 0);
      chk("t4_err_rst", mmio_err, 0);
      chk("t4_ahpar_rst", ah_mmdatapar, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ah_mmack) n_rst_ack++;
      end
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ah_mmack) n_rst_ack++;
      end
      chk("t4_no_ack", n_rst_ack, 0);
      run_req(1'b0, 1'b0, 24'h000008, 64'hCAFE, 1'b0, 0, 0, junk, 8);
      chk("t4_we_cycle", c_we, 2);
      chk("t4_wa", wa2, 25'h000010);
      chk("t4_wd", wd2, 64'hCAFE);
      chk("t4_ack_cycle", c_ack, 5);
      chk("t4_err", mmio_err, 0);

      // 5: second write one cycle after the first ack
      run_req(1'b0, 1'b1, 24'h000002, 64'h99, 1'b0, 6, 0, junk, 14);
      chk("t5_we_count", n_we, 2);
      chk("t5_we_last", c_we, 8);
      chk("t5_ack_count", n_ack, 2);
      chk("t5_ack_first", c_ack, 5);
      chk("t5_ack_last", c_ack_last, 11);
      chk("t5_wa", wa, 25'h000041);
      chk("t5_wd", wd, 64'h77);
      chk("t5_err", mmio_err, 0);
      chk("t5_both", n_both, 0);

`ifdef CAPI_MMIO_PARITY_EN
      // 6: flipped address parity on a write
      run_req(1'b0, 1'b1, 24'h000050, 64'h42, 1'b1, 0, 0, junk, 8);
      chk("t6_we_count", n_we, 0);
      chk("t6_re_count", n_re, 0);
      chk("t6_perr_count", n_perr, 1);
      chk("t6_perr_cycle", c_perr, 1);
      chk("t6_ack_count", n_ack, 1);
      chk("t6_ack_cycle", c_ack, 3);
      chk("t6_ack_data", ack_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_ack_par", ack_par, 1);
      run_req(1'b0, 1'b1, 24'h000010, 64'hA5, 1'b0, 0, 0, junk, 8);
      chk("t6_good_we", c_we, 2);
      chk("t6_good_perr", n_perr, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
